tag_issue_queue: RTL and testbench

Request-side companion of the reorder queue. Accepts in-order requests, allocates a sequence tag from the reorder queue per request (`rq_increment` / `rq_index_tag`), and forwards each request with its tag in the LSBs through a small output FIFO to the out-of-order responder. It counts outstanding tags, decremented on the reorder queue's in-order `valid` pulses, and checks that the queue's tag sequence is consistent.

---
 rtl/tag_issue_queue.sv | 166 ++++++++++++++++
 tb/tb_tag_issue_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_issue_queue.sv
// Small synchronous FIFO for tagged requests.
// Latency: push visible at the head the cycle after the write edge.
// Backpressure: full blocks push, no same-cycle pop bypass; empty ignores pop.
module tag_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells a full ring from an empty one.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// Tags in-order requests from the reorder queue and forwards them to the responder.
// Latency: accepted request appears on out_data one cycle later.
// Backpressure: in_ready drops on rq_full, full tag window, or full output FIFO.
module tag_issue_queue #(
    parameter int REQ_WIDTH = 32,
    parameter int DEPTH     = 32,
    parameter int TAG_WIDTH = $clog2(DEPTH-1)+1,
    parameter int OUT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [REQ_WIDTH-1:0]          in_data,
    output logic                          in_ready,
    output logic                          rq_increment,
    input  logic [TAG_WIDTH-1:0]          rq_index_tag,
    input  logic                          rq_full,
    input  logic                          retire,
    output logic                          out_valid,
    output logic [REQ_WIDTH+TAG_WIDTH-1:0] out_data,
    input  logic                          out_stall,
    output logic [TAG_WIDTH-1:0]          outstanding,
    output logic                          idle,
    output logic                          error
);
    localparam int INIT_W = $clog2(2*DEPTH);
    localparam logic [INIT_W-1:0]    INIT_LAST = INIT_W'(2*DEPTH-1);
    localparam logic [TAG_WIDTH-1:0] WINDOW    = TAG_WIDTH'(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [REQ_WIDTH-1:0] payload;
        logic [TAG_WIDTH-1:0] tag;
    } req_t;

    state_t               state;
    state_t               state_nxt;
    logic [INIT_W-1:0]    init_cnt;
    logic [TAG_WIDTH-1:0] exp_tag;
    logic                 run;
    logic                 accept;
    logic                 ret_ok;
    logic                 ret_err;
    logic                 fifo_full;
    logic                 fifo_empty;
    req_t                 push_dat;
    req_t                 head_dat;

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_cnt == INIT_LAST) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        run          = (state == RUN);
        in_ready     = run && !rq_full && (outstanding < WINDOW) && !fifo_full;
        accept       = in_valid && in_ready;
        rq_increment = accept;
        idle         = run && fifo_empty && (outstanding == '0);
    end

    // Counts out the reorder queue's reset sweep before the first request.
    always_ff @(posedge clk) begin
        if (rst)
            init_cnt <= '0;
        else if (state == INIT && init_cnt != INIT_LAST)
            init_cnt <= init_cnt + INIT_W'(1);
    end

    assign ret_ok  = run && retire && (outstanding != '0);
    assign ret_err = run && retire && (outstanding == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            exp_tag     <= '0;
            error       <= 1'b0;
        end else begin
            if (accept && !ret_ok)
                outstanding <= outstanding + TAG_WIDTH'(1);
            else if (!accept && ret_ok)
                outstanding <= outstanding - TAG_WIDTH'(1);
            if (accept)
                exp_tag <= exp_tag + TAG_WIDTH'(1);
            if (ret_err || (accept && rq_index_tag != exp_tag))
                error <= 1'b1;
        end
    end

    // A mismatched tag is still forwarded as the queue issued it.
    assign push_dat.payload = in_data;
    assign push_dat.tag     = rq_index_tag;

    tag_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (accept),
        .push_dat (push_dat),
        .pop_vld  (out_valid && !out_stall),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head_dat;
endmodule

// File: tb/tb_tag_issue_queue.sv
// Scoreboarded random bench for tag_issue_queue with a cycle-level reference model.
module tb_tag_issue_queue;
    localparam int RW = 32;
    localparam int D  = 32;
    localparam int TW = 6;
    localparam int OD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [RW-1:0] in_data;
    logic          in_ready;
    logic          rq_increment;
    logic [TW-1:0] rq_index_tag;
    logic          rq_full;
    logic          retire;
    logic          out_valid;
    logic [RW+TW-1:0] out_data;
    logic          out_stall;
    logic [TW-1:0] outstanding;
    logic          idle;
    logic          error;

    tag_issue_queue #(.REQ_WIDTH(RW), .DEPTH(D), .TAG_WIDTH(TW), .OUT_DEPTH(OD)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .rq_increment (rq_increment),
        .rq_index_tag (rq_index_tag),
        .rq_full      (rq_full),
        .retire       (retire),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_stall    (out_stall),
        .outstanding  (outstanding),
        .idle         (idle),
        .error        (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [RW+TW-1:0] sb[$];

    // Reference state: window occupancy, FIFO occupancy, INIT progress, tags.
    int            m_out;
    int            m_fifo;
    int            m_init;
    bit            m_run;
    bit            m_err;
    logic [TW-1:0] m_exp;
    logic [TW-1:0] m_tag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_out  = 0;
        m_fifo = 0;
        m_init = 0;
        m_run  = 0;
        m_err  = 0;
        m_exp  = '0;
        m_tag  = '0;
        sb.delete();
    endtask

    // Entered and left on a negedge; holds rst for n rising edges.
    task automatic do_reset(input int n);
        rst          = 1'b1;
        in_valid     = 1'b1;
        in_data      = 32'h1234_5678;
        rq_full      = 1'b0;
        retire       = 1'b1;
        out_stall    = 1'b0;
        rq_index_tag = '0;
        repeat (n) @(negedge clk);
        chk("rst_in_ready",     in_ready,     0);
        chk("rst_rq_increment", rq_increment, 0);
        chk("rst_out_valid",    out_valid,    0);
        chk("rst_outstanding",  outstanding,  0);
        chk("rst_idle",         idle,         0);
        chk("rst_error",        error,        0);
        rst      = 1'b0;
        in_valid = 1'b0;
        retire   = 1'b0;
        model_clear();
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registers.
    task automatic step(input bit v, input logic [RW-1:0] d, input bit full, input bit ret,
                        input bit stall, input bit force_tag = 1'b0, input logic [TW-1:0] ftag = '0);
        logic [TW-1:0] tag;
        bit exp_rdy;
        bit acc;
        bit pop;
        tag          = force_tag ? ftag : m_tag;
        in_valid     = v;
        in_data      = d;
        rq_full      = full;
        retire       = ret;
        out_stall    = stall;
        rq_index_tag = tag;
        #2;
        exp_rdy = m_run && !full && (m_out < D) && (m_fifo < OD);
        acc     = v && exp_rdy;
        pop     = (m_fifo > 0) && !stall;
        chk("in_ready",     in_ready,     exp_rdy);
        chk("rq_increment", rq_increment, acc);
        chk("out_valid",    out_valid,    m_fifo > 0);
        if (acc) begin
            sb.push_back({d, tag});
            if (tag != m_exp) m_err = 1;
            m_exp = m_exp + 1'b1;
            m_tag = m_tag + 1'b1;
        end
        if (m_run && ret) begin
            if (m_out == 0) m_err = 1;
            else            m_out = m_out - 1;
        end
        if (acc) m_out = m_out + 1;
        m_fifo = m_fifo + int'(acc) - int'(pop);
        if (!m_run) begin
            if (m_init == 2*D-1) m_run = 1;
            else                 m_init = m_init + 1;
        end
        @(negedge clk);
        chk("outstanding", outstanding, m_out);
        chk("error",       error,       m_err);
        chk("idle",        idle,        m_run && m_fifo == 0 && m_out == 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 48; i++) step(0, '0, 0, m_out > 0, 0);
    endtask

    // Monitor: head must match the oldest expected entry; pops on a non-stalled cycle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", out_data, '0);
                end else begin
                    chk("out_data", out_data, sb[0]);
                    if (!out_stall) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; rq_full = 1'b0; retire = 1'b0;
        out_stall = 1'b0; rq_index_tag = '0;
        model_clear();
        @(negedge clk);

        // Reset and INIT sweep: in_ready must rise only after edge 64.
        do_reset(3);
        for (int i = 0; i < 70; i++) step(0, '0, 0, i % 7 == 3, 0);

        // Single request, then retire to idle.
        step(1, 32'hDEAD_BEEF, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 0, 0);

        // Back-pressure: FIFO fills to OUT_DEPTH and head stays stable.
        for (int i = 0; i < 7; i++) step(1, $urandom, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, '0, 0, 0, 0);
        drain();

        // Window limit.
        for (int i = 0; i < 36; i++) step(1, $urandom, 0, 0, 0);
        step(1, $urandom, 0, 1, 0);
        step(1, $urandom, 0, 1, 0);
        step(1, $urandom, 0, 0, 0);
        step(1, $urandom, 0, 1, 0);
        drain();

        // Tag wrap from a clean reset: 70 accepts with continuous retire.
        do_reset(2);
        idle_cycles(64);
        for (int i = 0; i < 70; i++) step(1, $urandom, 0, m_out > 0, 0);
        chk("wrap_no_error", error, 0);
        drain();

        // Random traffic.
        do_reset(2);
        idle_cycles(64);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                 (m_out > 0) && $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        drain();
        chk("sb_empty_random", sb.size(), 0);

        // Tag mismatch: tag 5 offered when 3 is expected.
        do_reset(2);
        idle_cycles(64);
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, 0);
        step(1, 32'hCAFE_0005, 0, 0, 0, 1'b1, 6'd5);
        step(0, '0, 0, 0, 0);
        chk("tag_mismatch_error", error, 1);
        drain();

        // Retire with nothing outstanding; error sticks until reset.
        do_reset(2);
        idle_cycles(64);
        step(0, '0, 0, 1, 0);
        idle_cycles(4);
        chk("retire_underflow_error", error, 1);
        do_reset(2);
        idle_cycles(3);
        chk("sb_empty_end", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
